// File: rtl/operand_stack.sv
// operand_stack -- LIFO operand stack that feeds the ALU.
//   tos/nos expose the two top entries as the ALU's b/a operands; a BINOP
//   pops both and pushes the ALU result (din) in a single cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid, cmd    command strobe and code (NOP/PUSH/POP/BINOP/DUP/SWAP)
//   din               push data or ALU result
//   err_clr           synchronous clear of the sticky error flags
//   tos, nos          entry at count-1 / count-2, zero when absent
//   count, empty, full  occupancy
//   ovf_err, unf_err  sticky overflow / underflow flags
module operand_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_BINOP = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  op_e           op;
  logic [AW-1:0] idx_n;   // slot just above the top
  logic [AW-1:0] idx_m1;  // top slot
  logic [AW-1:0] idx_m2;  // slot below the top
  logic          has1;
  logic          has2;
  logic          room;
  logic          do_push;
  logic          do_pop;
  logic          do_binop;
  logic          do_dup;
  logic          do_swap;
  logic          ovf_hit;
  logic          unf_hit;
  logic [CW-1:0] count_next;

  assign op = op_e'(cmd);

  // Indices wrap modulo DEPTH; when count==DEPTH the low bits are zero, so
  // idx_m1/idx_m2 still land on DEPTH-1/DEPTH-2.
  assign idx_n  = count[AW-1:0];
  assign idx_m1 = idx_n - AW'(1);
  assign idx_m2 = idx_n - AW'(2);

  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));
  assign room = (count < CW'(DEPTH));

  assign empty = ~has1;
  assign full  = (count == CW'(DEPTH));
  assign tos   = has1 ? mem[idx_m1] : '0;
  assign nos   = has2 ? mem[idx_m2] : '0;

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_binop   = 1'b0;
    do_dup     = 1'b0;
    do_swap    = 1'b0;
    ovf_hit    = 1'b0;
    unf_hit    = 1'b0;
    count_next = count;
    if (cmd_valid) begin
      unique case (op)
        OP_PUSH: begin
          do_push = room;
          ovf_hit = ~room;
        end
        OP_POP: begin
          do_pop  = has1;
          unf_hit = ~has1;
        end
        OP_BINOP: begin
          do_binop = has2;
          unf_hit  = ~has2;
        end
        OP_DUP: begin
          do_dup  = has1 & room;
          unf_hit = ~has1;
          ovf_hit = has1 & ~room;
        end
        OP_SWAP: begin
          do_swap = has2;
          unf_hit = ~has2;
        end
        default: ;
      endcase
    end
    if (do_push || do_dup)
      count_next = count + CW'(1);
    else if (do_pop || do_binop)
      count_next = count - CW'(1);
  end

  // Storage deliberately has no reset; only count defines validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[idx_n] <= din;
    if (do_dup)
      mem[idx_n] <= mem[idx_m1];
    if (do_binop)
      mem[idx_m2] <= din;
    if (do_swap) begin
      mem[idx_m1] <= mem[idx_m2];
      mem[idx_m2] <= mem[idx_m1];
    end
  end

  // A new error in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= count_next;
      ovf_err <= ovf_hit | (ovf_err & ~err_clr);
      unf_err <= unf_hit | (unf_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam logic [2:0] C_NOP = 3'd0, C_PUSH = 3'd1, C_POP = 3'd2,
                         C_BINOP = 3'd3, C_DUP = 3'd4, C_SWAP = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd = '0;
  logic [WIDTH-1:0] din = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, ovf_err, unf_err;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .din(din),
    .err_clr(err_clr), .tos(tos), .nos(nos), .count(count), .empty(empty),
    .full(full), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [WIDTH-1:0] et, en;
    n  = q.size();
    et = (n >= 1) ? q[n-1] : '0;
    en = (n >= 2) ? q[n-2] : '0;
    chk({tag, ".tos"},   32'(tos),     32'(et));
    chk({tag, ".nos"},   32'(nos),     32'(en));
    chk({tag, ".count"}, 32'(count),   32'(n));
    chk({tag, ".empty"}, 32'(empty),   32'(n == 0));
    chk({tag, ".full"},  32'(full),    32'(n == DEPTH));
    chk({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
    chk({tag, ".unf"},   32'(unf_err), 32'(m_unf));
  endtask

  task automatic model_step(input logic v, input logic [2:0] c,
                            input logic [WIDTH-1:0] d, input logic clr);
    logic o, u;
    logic [WIDTH-1:0] a, b;
    int n;
    o = 1'b0;
    u = 1'b0;
    n = q.size();
    if (v) begin
      case (c)
        C_PUSH:  if (n < DEPTH) q.push_back(d); else o = 1'b1;
        C_POP:   if (n >= 1) void'(q.pop_back()); else u = 1'b1;
        C_BINOP: if (n >= 2) begin
                   void'(q.pop_back());
                   void'(q.pop_back());
                   q.push_back(d);
                 end else u = 1'b1;
        C_DUP:   if (n == 0) u = 1'b1;
                 else if (n == DEPTH) o = 1'b1;
                 else q.push_back(q[n-1]);
        C_SWAP:  if (n >= 2) begin
                   a = q.pop_back();
                   b = q.pop_back();
                   q.push_back(a);
                   q.push_back(b);
                 end else u = 1'b1;
        default: ;
      endcase
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_ovf = m_ovf | o;
    m_unf = m_unf | u;
  endtask

  task automatic step(input logic v, input logic [2:0] c,
                      input logic [WIDTH-1:0] d, input logic clr);
    @(negedge clk);
    cmd_valid = v;
    cmd       = c;
    din       = d;
    err_clr   = clr;
    @(posedge clk);
    model_step(v, c, d, clr);
    #1;
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] rc;
    // Reset
    do_reset();
    #1;
    check_all("reset");

    // Push two, then an ALU add result replaces them
    step(1, C_PUSH, 16'h0003, 0);
    step(1, C_PUSH, 16'h0005, 0);
    check_all("push2");
    chk("push2.tos_k", 32'(tos), 32'h5);
    chk("push2.nos_k", 32'(nos), 32'h3);
    step(1, C_BINOP, 16'h0008, 0);
    check_all("binop");
    chk("binop.tos_k", 32'(tos), 32'h8);
    chk("binop.cnt_k", 32'(count), 32'd1);

    // SWAP then DUP
    step(1, C_PUSH, 16'h1111, 0);
    step(1, C_PUSH, 16'h2222, 0);
    step(1, C_SWAP, 16'h0, 0);
    check_all("swap");
    chk("swap.tos_k", 32'(tos), 32'h1111);
    chk("swap.nos_k", 32'(nos), 32'h2222);
    step(1, C_DUP, 16'h0, 0);
    check_all("dup");
    chk("dup.nos_k", 32'(nos), 32'h1111);
    chk("dup.cnt_k", 32'(count), 32'd4);

    // Drain, then underflow and sticky-clear precedence
    for (int i = 0; i < 4; i++) step(1, C_POP, 16'h0, 0);
    check_all("drain");
    step(1, C_POP, 16'h0, 0);
    check_all("pop_empty");
    chk("pop_empty.unf_k", 32'(unf_err), 32'd1);
    step(1, C_POP, 16'h0, 1);
    check_all("clr_vs_err");
    chk("clr_vs_err.unf_k", 32'(unf_err), 32'd1);
    step(0, C_NOP, 16'h0, 1);
    check_all("clr_alone");
    chk("clr_alone.unf_k", 32'(unf_err), 32'd0);

    // Underflow on binop/swap/dup with too few entries, invalid strobe ignored
    step(1, C_DUP, 16'h0, 0);
    check_all("dup_empty");
    step(1, C_PUSH, 16'hABCD, 1);
    step(1, C_BINOP, 16'h1234, 0);
    check_all("binop_short");
    step(1, C_SWAP, 16'h0, 1);
    check_all("swap_short");
    step(0, C_PUSH, 16'h5555, 0);
    check_all("no_valid");

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      rc = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 9) != 0), rc, 16'($urandom),
           ($urandom_range(0, 7) == 0));
      check_all("rand");
    end

    // Fill to full, overflow, DUP at full
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, C_PUSH, 16'(i), 0);
    check_all("fill");
    chk("fill.full_k", 32'(full), 32'd1);
    chk("fill.tos_k", 32'(tos), 32'h000F);
    step(1, C_PUSH, 16'hFFFF, 0);
    check_all("push_full");
    chk("push_full.ovf_k", 32'(ovf_err), 32'd1);
    chk("push_full.tos_k", 32'(tos), 32'h000F);
    chk("push_full.cnt_k", 32'(count), 32'd16);
    step(1, C_DUP, 16'h0, 1);
    check_all("dup_full");

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_all("async_rst");
    chk("async_rst.cnt_k", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, C_PUSH, 16'h4242, 0);
    check_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
